// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler: allocates entries and tracks their relative age in
// an age matrix. Each cycle it picks the oldest ready entry into a valid/ready issue register.
module rs_issue_scheduler #(
    parameter int NUM_RS_ENTRIES = 8,
    parameter int IDX_W          = $clog2(NUM_RS_ENTRIES),
    parameter int CNT_W          = $clog2(NUM_RS_ENTRIES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_valid_i,
    output logic                      alloc_ready_o,
    output logic [IDX_W-1:0]          alloc_idx_o,
    input  logic [NUM_RS_ENTRIES-1:0] ready_vector_i,
    output logic                      issue_valid_o,
    output logic [IDX_W-1:0]          issue_idx_o,
    input  logic                      issue_ready_i,
    input  logic                      flush_i,
    output logic [NUM_RS_ENTRIES-1:0] valid_vector_o,
    output logic [CNT_W-1:0]          occupancy_o
);
    localparam int N = NUM_RS_ENTRIES;

    // age_q[j][i] set means entry j is older than entry i
    logic [N-1:0]          valid_q;
    logic [N-1:0][N-1:0]   age_q;
    logic                  issue_valid_q;
    logic [IDX_W-1:0]      issue_idx_q;

    logic [N-1:0]          held;
    logic [N-1:0]          cand;
    logic [N-1:0]          grant;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      free_idx;
    logic [CNT_W-1:0]      pop;
    logic                  alloc_fire;
    logic                  accept;
    logic                  any_cand;
    logic                  load_issue;

    always_comb begin
        free_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
        pop = '0;
        for (int i = 0; i < N; i++) pop = pop + CNT_W'(valid_q[i]);
    end

    // The held entry must not be re-picked while waiting for or just after acceptance.
    always_comb begin
        held = '0;
        if (issue_valid_q) held[issue_idx_q] = 1'b1;
        cand = valid_q & ready_vector_i & ~held;
    end

    always_comb begin
        grant    = '0;
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (j != i && cand[j] && age_q[j][i]) blocked = 1'b1;
            end
            grant[i] = cand[i] & ~blocked;
        end
        for (int i = 0; i < N; i++) begin
            if (grant[i]) pick_idx = IDX_W'(i);
        end
    end

    assign alloc_ready_o  = |(~valid_q);
    assign alloc_idx_o    = free_idx;
    assign alloc_fire     = alloc_valid_i & alloc_ready_o;
    assign accept         = issue_valid_q & issue_ready_i;
    assign any_cand       = |cand;
    assign load_issue     = (~issue_valid_q | issue_ready_i) & any_cand;
    assign issue_valid_o  = issue_valid_q;
    assign issue_idx_o    = issue_idx_q;
    assign valid_vector_o = valid_q;
    assign occupancy_o    = pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            age_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
        end else if (flush_i) begin
            valid_q       <= '0;
            age_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
        end else begin
            if (accept) valid_q[issue_idx_q] <= 1'b0;
            // Allocated slot is free in valid_q, so it never collides with the accepted one.
            if (alloc_fire) begin
                valid_q[free_idx] <= 1'b1;
                for (int j = 0; j < N; j++) begin
                    age_q[free_idx][j] <= 1'b0;
                    age_q[j][free_idx] <= valid_q[j];
                end
            end
            if (load_issue) begin
                issue_valid_q <= 1'b1;
                issue_idx_q   <= pick_idx;
            end else if (accept) begin
                issue_valid_q <= 1'b0;
                issue_idx_q   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Bench for rs_issue_scheduler: directed scenarios plus random traffic, every cycle checked
// against an allocation-order queue model.
module tb_rs_issue_scheduler;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alloc_valid = 1'b0;
    logic       alloc_ready;
    logic [2:0] alloc_idx;
    logic [7:0] ready_vector = '0;
    logic       issue_valid;
    logic [2:0] issue_idx;
    logic       issue_ready = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] valid_vector;
    logic [3:0] occupancy;

    int tests = 0;
    int fails = 0;

    // model: set of live entries, their allocation order (oldest first), issue register
    logic [7:0] m_valid;
    int         m_order[$];
    logic       m_iv;
    int         m_iidx;

    rs_issue_scheduler #(.NUM_RS_ENTRIES(N)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_idx_o(alloc_idx),
        .ready_vector_i(ready_vector),
        .issue_valid_o(issue_valid), .issue_idx_o(issue_idx), .issue_ready_i(issue_ready),
        .flush_i(flush), .valid_vector_o(valid_vector), .occupancy_o(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_valid = '0;
        m_order.delete();
        m_iv    = 1'b0;
        m_iidx  = 0;
    endtask

    task automatic check_all();
        check("alloc_ready", alloc_ready, (m_order.size() < N));
        check("alloc_idx", alloc_idx, lowest_free());
        check("issue_valid", issue_valid, m_iv);
        if (m_iv) check("issue_idx", issue_idx, m_iidx);
        check("valid_vector", valid_vector, m_valid);
        check("occupancy", occupancy, m_order.size());
    endtask

    task automatic model_edge();
        int  pick;
        bit  found;
        bit  acc;
        bit  afire;
        int  aidx;
        int  old;
        if (flush) begin
            model_reset();
            return;
        end
        acc   = m_iv && issue_ready;
        afire = alloc_valid && (m_order.size() < N);
        aidx  = lowest_free();
        old   = m_iidx;
        found = 0;
        pick  = 0;
        foreach (m_order[k]) begin
            if (!found && ready_vector[m_order[k]] && !(m_iv && m_order[k] == m_iidx)) begin
                found = 1;
                pick  = m_order[k];
            end
        end
        if ((!m_iv || issue_ready) && found) begin
            m_iv = 1'b1; m_iidx = pick;
        end else if (acc) begin
            m_iv = 1'b0; m_iidx = 0;
        end
        if (acc) begin
            m_valid[old] = 1'b0;
            foreach (m_order[k]) if (m_order[k] == old) begin m_order.delete(k); break; end
        end
        if (afire) begin
            m_valid[aidx] = 1'b1;
            m_order.push_back(aidx);
        end
    endtask

    task automatic tick();
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_issue_valid", issue_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_alloc_idx", alloc_idx, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        alloc_valid = 0; ready_vector = '0; issue_ready = 0; flush = 0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // T2 ordering across allocations
        alloc_valid = 1; ready_vector = 8'b110; issue_ready = 1;
        tick(); tick(); tick();
        alloc_valid = 0;
        check("t2_first_valid", issue_valid, 1);
        check("t2_first_idx", issue_idx, 1);
        tick();
        check("t2_second_idx", issue_idx, 2);
        tick();
        check("t2_drained", issue_valid, 0);
        ready_vector = 8'b111;
        tick();
        check("t2_third_idx", issue_idx, 0);
        tick(); tick();

        // T3 age beats index
        do_reset();
        alloc_valid = 1;
        repeat (8) tick();
        alloc_valid = 0; ready_vector = 8'h08; issue_ready = 1;
        tick();
        ready_vector = 8'h00;
        tick();
        alloc_valid = 1;
        check("t3_realloc_idx", alloc_idx, 3);
        tick();
        alloc_valid = 0; ready_vector = 8'h88;
        tick();
        check("t3_oldest_first", issue_idx, 7);
        tick();
        check("t3_then_young", issue_idx, 3);
        ready_vector = 8'h00;
        tick();

        // T4 backpressure with dropped ready on the held entry
        ready_vector = 8'h01; issue_ready = 0;
        tick();
        ready_vector = 8'h02;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t4_hold_valid", issue_valid, 1);
            check("t4_hold_idx", issue_idx, 0);
            check("t4_hold_occ", occupancy, 6);
        end
        issue_ready = 1;
        tick();
        check("t4_next_idx", issue_idx, 1);
        ready_vector = 0;
        tick();

        // T5 full and simultaneous alloc + accept
        do_reset();
        alloc_valid = 1;
        repeat (8) tick();
        alloc_valid = 0;
        check("t5_full_ready", alloc_ready, 0);
        check("t5_full_occ", occupancy, 8);
        ready_vector = 8'h20;
        tick();
        ready_vector = 0; issue_ready = 1; alloc_valid = 1;
        tick();
        alloc_valid = 0;
        check("t5_ready_again", alloc_ready, 1);
        check("t5_free_idx", alloc_idx, 5);
        check("t5_occ", occupancy, 7);
        tick();

        // T6 flush beats alloc and accept
        do_reset();
        alloc_valid = 1;
        repeat (4) tick();
        alloc_valid = 0; ready_vector = 8'h01;
        tick();
        flush = 1; alloc_valid = 1; issue_ready = 1;
        tick();
        flush = 0; alloc_valid = 0;
        check("t6_valid_vec", valid_vector, 0);
        check("t6_issue_valid", issue_valid, 0);
        check("t6_occ", occupancy, 0);
        tick();

        // random traffic, then T1 mid-run async reset, then more traffic
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 300; c++) begin
                alloc_valid  = ($urandom_range(0, 99) < 60);
                ready_vector = 8'($urandom);
                issue_ready  = ($urandom_range(0, 99) < 60);
                flush        = ($urandom_range(0, 99) < 2);
                tick();
            end
            flush = 0;
            if (r == 0) do_reset();
        end
        alloc_valid = 0; flush = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
